// File: rtl/bball_pkg.sv
// Shared constants and types for the basketball shot block.
// Optional feature macro: THREE_POINT_EN (long shots score 3 points).
package bball_pkg;

  typedef enum logic [1:0] {
    HELD   = 2'd0,
    FLIGHT = 2'd1,
    SCORED = 2'd2,
    DEAD   = 2'd3
  } ball_state_e;

  // Hoop windows (ball centre, inclusive), signed to match position maths
  localparam logic signed [10:0] HOOP_R_X_LO = 11'sd560;
  localparam logic signed [10:0] HOOP_R_X_HI = 11'sd584;
  localparam logic signed [10:0] HOOP_L_X_LO = 11'sd56;
  localparam logic signed [10:0] HOOP_L_X_HI = 11'sd80;
  localparam logic signed [10:0] HOOP_Y_LO   = 11'sd150;
  localparam logic signed [10:0] HOOP_Y_HI   = 11'sd160;
  localparam logic [9:0]         HOOP_R_CX   = 10'd572;
  localparam logic [9:0]         HOOP_L_CX   = 10'd68;

  // Playfield limits
  localparam logic signed [10:0] FLOOR_Y      = 11'sd370;
  localparam logic signed [10:0] SCREEN_MAX_X = 11'sd639;

  // Motion
  localparam logic signed [5:0] LAUNCH_VX_R = 6'sd3;
  localparam logic signed [5:0] LAUNCH_VX_L = -6'sd3;
  localparam logic signed [5:0] LAUNCH_VY   = -6'sd12;
  localparam logic signed [5:0] GRAVITY     = 6'sd1;
  localparam logic signed [5:0] VY_CAP      = 6'sd15;
  localparam logic signed [5:0] VEL_ZERO    = 6'sd0;

  // Post-shot countdown
  localparam logic [5:0] COOLDOWN = 6'd60;
  localparam logic [5:0] CD_STEP  = 6'd1;
  localparam logic [5:0] CD_ZERO  = 6'd0;

  // Scoring
  localparam logic [11:0] THREE_PT_DIST = 12'd200;
  localparam logic [1:0]  PTS_ZERO      = 2'd0;
  localparam logic [1:0]  PTS_TWO       = 2'd2;
  localparam logic [1:0]  PTS_THREE     = 2'd3;

  // Ball position relative to the player sprite while held
  localparam logic [9:0] HELD_DX_R     = 10'd28;
  localparam logic [9:0] HELD_DX_L_MAG = 10'd8;   // held offset is -8 facing left
  localparam logic [9:0] HELD_DY       = 10'd20;
  localparam logic [9:0] POS_ZERO      = 10'd0;

  // Reset position: player at (373,300) facing right
  localparam logic [9:0] RST_X = 10'd401;
  localparam logic [9:0] RST_Y = 10'd320;

  // Points for a basket given the release X and the hoop centre hit
  function automatic logic [1:0] shot_points(input logic [9:0] rel_x,
                                             input logic [9:0] centre);
    logic signed [11:0] d;
    d = $signed({2'b00, rel_x}) - $signed({2'b00, centre});
    if (d < 0) d = -d;
    return ($unsigned(d) > THREE_PT_DIST) ? PTS_THREE : PTS_TWO;
  endfunction

endpackage

// File: rtl/hoop_hit.sv
// Combinational hoop detector: candidate ball centre inside either hoop
// window while the ball is falling (vy > 0).
module hoop_hit
  import bball_pkg::*;
(
  input  logic signed [10:0] cand_x,
  input  logic signed [10:0] cand_y,
  input  logic signed [5:0]  vy,
  output logic               hit_left,
  output logic               hit_right
);

  logic falling, in_y;

  // Window tests on the signed candidate position
  always_comb begin
    falling   = (vy > VEL_ZERO);
    in_y      = (cand_y >= HOOP_Y_LO) && (cand_y <= HOOP_Y_HI);
    hit_right = falling && in_y && (cand_x >= HOOP_R_X_LO) && (cand_x <= HOOP_R_X_HI);
    hit_left  = falling && in_y && (cand_x >= HOOP_L_X_LO) && (cand_x <= HOOP_L_X_HI);
  end

endmodule

// File: rtl/ball_shot.sv
// Ball held / in flight / scored / dead controller, one update per frame.
// Optional feature macro: THREE_POINT_EN (score 3 for long release distance).
module ball_shot
  import bball_pkg::*;
(
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       shoot,
  input  logic       dir,
  input  logic [9:0] playerX,
  input  logic [9:0] playerY,
  input  logic       endGame,
  output logic [9:0] ballX,
  output logic [9:0] ballY,
  output logic [1:0] ball_state,
  output logic       score_pulse,
  output logic       miss_pulse,
  output logic [1:0] score_value
);

  ball_state_e       state_q, state_d;
  logic [9:0]        bx_q, bx_d, by_q, by_d;
  logic signed [5:0] vx_q, vx_d, vy_q, vy_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              shoot_prev_q;
  logic              sp_q, sp_d, mp_q, mp_d;
  logic [1:0]        sv_q, sv_d;
`ifdef THREE_POINT_EN
  logic [9:0]        relx_q, relx_d;
`endif

  logic [9:0]        held_x, held_y;
  logic signed [10:0] nx, ny;
  logic signed [5:0] vy_inc;
  logic              hit_l, hit_r, miss;

  // Held position, candidate flight position and miss test
  always_comb begin
    if (dir)                        held_x = playerX + HELD_DX_R;
    else if (playerX >= HELD_DX_L_MAG) held_x = playerX - HELD_DX_L_MAG;
    else                            held_x = POS_ZERO;
    held_y = playerY + HELD_DY;
    nx     = $signed({1'b0, bx_q}) + $signed({{5{vx_q[5]}}, vx_q});
    ny     = $signed({1'b0, by_q}) + $signed({{5{vy_q[5]}}, vy_q});
    vy_inc = (vy_q >= VY_CAP) ? VY_CAP : vy_q + GRAVITY;
    miss   = nx[10] || (ny >= FLOOR_Y) || (nx > SCREEN_MAX_X);
  end

  hoop_hit u_hoop (
    .cand_x   (nx),
    .cand_y   (ny),
    .vy       (vy_q),
    .hit_left (hit_l),
    .hit_right(hit_r)
  );

  // Next-state, motion and pulse logic; everything holds while endGame is high
  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    cnt_d   = cnt_q;
    sp_d    = 1'b0;
    mp_d    = 1'b0;
    sv_d    = PTS_ZERO;
`ifdef THREE_POINT_EN
    relx_d  = relx_q;
`endif
    if (!endGame) begin
      case (state_q)
        HELD: begin
          bx_d = held_x;
          by_d = held_y;
          if (shoot && !shoot_prev_q) begin
            state_d = FLIGHT;
            vx_d    = dir ? LAUNCH_VX_R : LAUNCH_VX_L;
            vy_d    = LAUNCH_VY;
`ifdef THREE_POINT_EN
            relx_d  = held_x;
`endif
          end
        end
        FLIGHT: begin
          // Negative candidates only occur on a miss; clamp what is displayed
          bx_d = nx[10] ? POS_ZERO : nx[9:0];
          by_d = ny[10] ? POS_ZERO : ny[9:0];
          vy_d = vy_inc;
          if (hit_l || hit_r) begin
            state_d = SCORED;
            cnt_d   = COOLDOWN;
            sp_d    = 1'b1;
`ifdef THREE_POINT_EN
            sv_d    = shot_points(relx_q, hit_r ? HOOP_R_CX : HOOP_L_CX);
`else
            sv_d    = PTS_TWO;
`endif
          end else if (miss) begin
            state_d = DEAD;
            cnt_d   = COOLDOWN;
            mp_d    = 1'b1;
          end
        end
        default: begin
          cnt_d = cnt_q - CD_STEP;
          if (cnt_q <= CD_STEP) begin
            cnt_d   = CD_ZERO;
            state_d = HELD;
          end
        end
      endcase
    end
  end

  // State register; Reset overrides endGame and every state
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q      <= HELD;
      bx_q         <= RST_X;
      by_q         <= RST_Y;
      vx_q         <= VEL_ZERO;
      vy_q         <= VEL_ZERO;
      cnt_q        <= CD_ZERO;
      shoot_prev_q <= 1'b1;
      sp_q         <= 1'b0;
      mp_q         <= 1'b0;
      sv_q         <= PTS_ZERO;
`ifdef THREE_POINT_EN
      relx_q       <= POS_ZERO;
`endif
    end else begin
      state_q      <= state_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
      cnt_q        <= cnt_d;
      shoot_prev_q <= shoot;
      sp_q         <= sp_d;
      mp_q         <= mp_d;
      sv_q         <= sv_d;
`ifdef THREE_POINT_EN
      relx_q       <= relx_d;
`endif
    end
  end

  assign ballX       = bx_q;
  assign ballY       = by_q;
  assign ball_state  = state_q;
  assign score_pulse = sp_q;
  assign miss_pulse  = mp_q;
  assign score_value = sv_q;

endmodule

// File: tb/tb_ball_shot.sv
// Scoreboard bench for ball_shot: a frame-level model predicts the outputs
// after each edge; a monitor compares them one step after the edge.
module tb_ball_shot;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1, shoot = 1'b0, dir = 1'b1, endGame = 1'b0;
  logic [9:0] playerX = 10'd373, playerY = 10'd300;
  logic [9:0] ballX, ballY;
  logic [1:0] ball_state, score_value;
  logic       score_pulse, miss_pulse;

  ball_shot dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .shoot      (shoot),
    .dir        (dir),
    .playerX    (playerX),
    .playerY    (playerY),
    .endGame    (endGame),
    .ballX      (ballX),
    .ballY      (ballY),
    .ball_state (ball_state),
    .score_pulse(score_pulse),
    .miss_pulse (miss_pulse),
    .score_value(score_value)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct { int x; int y; int st; int sp; int mp; int sv; } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  int n_score = 0, n_miss = 0;

  // Stimulus intent, applied at the next falling edge
  bit c_r = 1, c_s = 0, c_d = 1, c_eg = 0;
  int c_px = 373, c_py = 300;

  // Model state: plain game rules on integers
  int m_st, m_x, m_y, m_vx, m_vy, m_cnt, m_prev, m_rel;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model();
    int hx, nx, ny, c;
    bit hit;
    exp_t e;
    e.sp = 0; e.mp = 0; e.sv = 0;
    if (Reset) begin
      m_st = 0; m_x = 401; m_y = 320; m_vx = 0; m_vy = 0; m_cnt = 0; m_prev = 1; m_rel = 0;
    end else begin
      if (!endGame) begin
        if (m_st == 0) begin
          hx = dir ? playerX + 28 : (playerX >= 8 ? playerX - 8 : 0);
          if (shoot && !m_prev) begin
            m_st = 1; m_vx = dir ? 3 : -3; m_vy = -12; m_rel = hx % 1024;
          end
          m_x = hx % 1024; m_y = (playerY + 20) % 1024;
        end else if (m_st == 1) begin
          nx = m_x + m_vx; ny = m_y + m_vy;
          hit = (m_vy > 0) && ny >= 150 && ny <= 160 &&
                ((nx >= 560 && nx <= 584) || (nx >= 56 && nx <= 80));
          if (hit) begin
            m_st = 2; m_cnt = 60; e.sp = 1; e.sv = 2;
`ifdef THREE_POINT_EN
            c = (nx >= 560) ? 572 : 68;
            if (m_rel - c > 200 || c - m_rel > 200) e.sv = 3;
`else
            c = 0;
`endif
          end else if (ny >= 370 || nx < 0 || nx > 639) begin
            m_st = 3; m_cnt = 60; e.mp = 1;
          end
          m_x = nx < 0 ? 0 : nx;
          m_y = ny < 0 ? 0 : ny;
          m_vy = (m_vy + 1 > 15) ? 15 : m_vy + 1;
        end else begin
          m_cnt--;
          if (m_cnt == 0) m_st = 0;
        end
      end
      m_prev = shoot;
    end
    e.x = m_x; e.y = m_y; e.st = m_st;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge frame_clk);
      Reset = c_r; shoot = c_s; dir = c_d; endGame = c_eg;
      playerX = 10'(c_px); playerY = 10'(c_py);
      model();
    end
  endtask

  // Monitor: compare every predicted frame one step after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge frame_clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ballX", int'(ballX), e.x);
        chk("ballY", int'(ballY), e.y);
        chk("ball_state", int'(ball_state), e.st);
        chk("score_pulse", int'(score_pulse), e.sp);
        chk("miss_pulse", int'(miss_pulse), e.mp);
        chk("score_value", int'(score_value), e.sv);
        chk("pulse_exclusive", int'(score_pulse & miss_pulse), 0);
        if (e.sp) n_score++;
        if (e.mp) n_miss++;
      end
    end
  end

  initial begin
    // Reset with player at (373,300) facing right, shoot held through reset
    c_r = 1; c_s = 1; tick(2);
    c_r = 0; tick(3);
    c_s = 0; tick(2);
    // Launch and keep shoot high through flight, DEAD and 100 HELD frames
    c_s = 1; tick(29 + 60 + 100);
    c_s = 0; tick(2);
    c_s = 1; tick(5);
    c_s = 0; tick(100);
    // Left launch from playerX=10: immediate left-edge miss, then cooldown
    c_d = 0; c_px = 10; tick(2);
    c_s = 1; tick(1); c_s = 0; tick(70);
    // Basket: release at (527,225) reaches (572,150) with vy=+2
    c_d = 1; c_px = 499; c_py = 205; tick(2);
    c_s = 1; tick(1); c_s = 0; tick(80);
    // Freeze mid-flight, then resume
    c_px = 373; c_py = 300; tick(2);
    c_s = 1; tick(1); c_s = 0; tick(5);
    c_eg = 1; c_s = 1; tick(10);
    c_eg = 0; c_s = 0; tick(4);
    // Reset mid-flight with shoot held
    c_s = 1; tick(1); c_s = 0; tick(4);
    c_s = 1; c_r = 1; tick(1);
    c_r = 0; tick(5);
    c_s = 0; tick(3);
    // Randomized play
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) c_s = ~c_s;
      if ($urandom_range(0, 31) == 0) c_d = $urandom_range(0, 1);
      if ($urandom_range(0, 31) == 0) c_px = $urandom_range(0, 611);
      if ($urandom_range(0, 31) == 0) c_py = $urandom_range(100, 360);
      if ($urandom_range(0, 63) == 0) c_eg = ~c_eg;
      c_r = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    c_r = 0; c_eg = 0; c_s = 0; tick(2);
    @(posedge frame_clk); #2;
    chk("queue_drained", q.size(), 0);
    chk("baskets_seen_min", int'(n_score >= 1), 1);
    chk("misses_seen_min", int'(n_miss >= 2), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
